// File: rtl/xcore_sum_sequencer_if.sv
// FIFO-side handshake bundle for the cross-core partial-sum exchange:
// outgoing write port (sum_out*) and incoming first-word-fall-through read port (sum_in*).
interface xcore_sum_sequencer_if #(parameter int bw_psum = 20);
  logic [bw_psum+3:0] sum_out;
  logic               sum_out_vld;
  logic               fifo_full;
  logic [bw_psum+3:0] sum_in;
  logic               sum_rd_vld;
  logic               fifo_ext_rd;

  modport master (output sum_out, sum_out_vld, fifo_ext_rd,
                  input  fifo_full, sum_in, sum_rd_vld);
  modport slave  (input  sum_out, sum_out_vld, fifo_ext_rd,
                  output fifo_full, sum_in, sum_rd_vld);
endinterface

// File: rtl/xcore_sum_sequencer.sv
// Per-core sequencer: captures each local row sum, exchanges it with the peer core
// through the async FIFOs (dual-core mode) and emits the combined row total.
module xcore_sum_sequencer #(
  parameter int bw_psum = 20,
  parameter int rows    = 8,
  parameter int tw      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       psum_vld,
  input  logic [bw_psum+3:0]         psum_in,
  xcore_sum_sequencer_if.master      fifo,
  output logic [bw_psum+4:0]         total_sum,
  output logic                       total_vld,
  output logic [$clog2(rows+1)-1:0]  row_cnt,
  output logic                       done,
  output logic                       err,
  output logic                       overrun
);
  localparam int RW = $clog2(rows+1);
  localparam int SW = bw_psum + 5;
  // Last counter value before the 2**tw-1 timeout limit is reached.
  localparam logic [tw-1:0] TMO_LAST = ~tw'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCAL, S_PUSH, S_WAIT_REMOTE, S_COMBINE, S_DONE, S_ERR
  } state_t;

  state_t             state, nxt;
  logic               mode_r;
  logic [bw_psum+3:0] local_reg, remote_reg;
  logic [tw-1:0]      tmo;
  logic               start_ok, last_row;

  assign start_ok     = start && (state == S_IDLE || state == S_ERR);
  assign last_row     = (row_cnt == RW'(rows - 1));
  assign fifo.sum_out = local_reg;

  always_comb begin
    nxt              = state;
    fifo.sum_out_vld = 1'b0;
    fifo.fifo_ext_rd = 1'b0;
    case (state)
      S_IDLE, S_ERR: if (start) nxt = S_WAIT_LOCAL;
      S_WAIT_LOCAL:  if (psum_vld) nxt = mode_r ? S_PUSH : S_COMBINE;
      S_PUSH: begin
        fifo.sum_out_vld = ~fifo.fifo_full;
        if (!fifo.fifo_full) nxt = S_WAIT_REMOTE;
      end
      S_WAIT_REMOTE: begin
        fifo.fifo_ext_rd = fifo.sum_rd_vld;
        if (fifo.sum_rd_vld)     nxt = S_COMBINE;
        else if (tmo == TMO_LAST) nxt = S_ERR;
      end
      S_COMBINE: nxt = last_row ? S_DONE : S_WAIT_LOCAL;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_r     <= 1'b0;
      local_reg  <= '0;
      remote_reg <= '0;
      tmo        <= '0;
      total_sum  <= '0;
      total_vld  <= 1'b0;
      row_cnt    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state     <= nxt;
      total_vld <= 1'b0;
      done      <= 1'b0;
      if (start_ok) begin
        mode_r  <= mode;
        row_cnt <= '0;
        err     <= 1'b0;
        overrun <= 1'b0;
      end
      // A dropped sum is reported even if it coincides with a restart.
      if (psum_vld && state != S_WAIT_LOCAL) overrun <= 1'b1;
      if (state == S_WAIT_REMOTE) begin
        if (!fifo.sum_rd_vld) tmo <= tmo + tw'(1);
      end else begin
        tmo <= '0;
      end
      case (state)
        S_WAIT_LOCAL:  if (psum_vld) local_reg <= psum_in;
        S_WAIT_REMOTE: begin
          if (fifo.sum_rd_vld)       remote_reg <= fifo.sum_in;
          else if (tmo == TMO_LAST)  err        <= 1'b1;
        end
        S_COMBINE: begin
          total_sum <= mode_r ? SW'(local_reg) + SW'(remote_reg) : SW'(local_reg);
          total_vld <= 1'b1;
          row_cnt   <= row_cnt + RW'(1);
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xcore_sum_sequencer.sv
// Bench for xcore_sum_sequencer: table-driven passes, timeout/reset sequences and
// randomized passes checked against an arithmetic latency/total model.
module tb_xcore_sum_sequencer;
  localparam int BW = 20, W = BW + 4, ROWS = 8, TW = 4, RW = $clog2(ROWS + 1);

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, psum_vld = 1'b0;
  logic [W-1:0]  psum_in = '0;
  logic [W:0]    total_sum;
  logic          total_vld, done, err, overrun;
  logic [RW-1:0] row_cnt;
  int            n_chk = 0, n_pass = 0;

  xcore_sum_sequencer_if #(.bw_psum(BW)) fifo_if ();

  xcore_sum_sequencer #(.bw_psum(BW), .rows(ROWS), .tw(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .psum_vld(psum_vld),
    .psum_in(psum_in), .fifo(fifo_if), .total_sum(total_sum), .total_vld(total_vld),
    .row_cnt(row_cnt), .done(done), .err(err), .overrun(overrun));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit           md;
    logic [W-1:0] ps, rm;
    int           nf, ne;   // fifo_full cycles, missing sum_rd_vld cycles
    bit           ovr, smid; // stray psum_vld in WAIT_REMOTE, start mid-row
    logic [W:0]   exp;
  } vec_t;
  vec_t vt[32];

  // Reference model: combined total and psum_vld -> total_vld latency.
  function automatic logic [W:0] ref_total(bit md, logic [W-1:0] a, logic [W-1:0] b);
    return md ? ({1'b0, a} + {1'b0, b}) : {1'b0, a};
  endfunction
  function automatic int ref_lat(bit md, int nf, int ne);
    return md ? 4 + nf + ne : 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    start = 1'b0; psum_vld = 1'b0;
    fifo_if.fifo_full = 1'b0; fifo_if.sum_rd_vld = 1'b0; fifo_if.sum_in = '0;
  endtask

  task automatic run_row(input vec_t v, input int idx, input string tag);
    int lat_exp, wr, rd, both, dn, tv_c;
    logic [W:0] tv_val;
    logic [W-1:0] so;
    logic [RW-1:0] rc;
    lat_exp = ref_lat(v.md, v.nf, v.ne);
    wr = 0; rd = 0; both = 0; dn = 0; tv_c = -1; tv_val = '0; so = '0; rc = '0;
    for (int c = 0; c < 64 && tv_c < 0; c++) begin
      psum_vld = (c == 0) || (v.ovr && c == 2 + v.nf);
      psum_in  = (c == 0) ? v.ps : W'($urandom);
      start    = v.smid && c == 1;
      mode     = (v.smid && c == 1) ? ~v.md : v.md;
      fifo_if.fifo_full  = v.md && c >= 1 && c <= v.nf;
      fifo_if.sum_rd_vld = v.md && rd == 0 && c >= 2 + v.nf + v.ne;
      fifo_if.sum_in     = fifo_if.sum_rd_vld ? v.rm : W'($urandom);
      #1;
      if (fifo_if.sum_out_vld) begin wr++; so = fifo_if.sum_out; end
      if (fifo_if.fifo_ext_rd) rd++;
      if (fifo_if.sum_out_vld && fifo_if.fifo_ext_rd) both++;
      if (done) dn++;
      if (total_vld) begin tv_c = c; tv_val = total_sum; rc = row_cnt; end
      adv();
    end
    idle_in();
    chk($sformatf("%s_r%0d_latency", tag, idx), tv_c, lat_exp);
    chk($sformatf("%s_r%0d_total", tag, idx), tv_val, v.exp);
    chk($sformatf("%s_r%0d_row_cnt", tag, idx), rc, idx + 1);
    chk($sformatf("%s_r%0d_writes", tag, idx), wr, v.md);
    chk($sformatf("%s_r%0d_reads", tag, idx), rd, v.md);
    if (v.md) chk($sformatf("%s_r%0d_sum_out", tag, idx), so, v.ps);
    chk($sformatf("%s_r%0d_strobe_overlap", tag, idx), both, 0);
    chk($sformatf("%s_r%0d_early_done", tag, idx), dn, 0);
  endtask

  task automatic do_start(input bit md, input string tag);
    start = 1'b1; mode = md;
    adv();
    start = 1'b0;
    chk({tag, "_start_row_cnt"}, row_cnt, 0);
    chk({tag, "_start_err"}, err, 0);
  endtask

  task automatic run_pass(input int base, input bit md, input bit exp_ovr, input string tag);
    do_start(md, tag);
    for (int i = 0; i < ROWS; i++) run_row(vt[base + i], i, tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_final_row_cnt"}, row_cnt, ROWS);
    chk({tag, "_overrun"}, overrun, exp_ovr);
    adv();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic fill_random(input int base, input bit md);
    for (int i = 0; i < ROWS; i++) begin
      vt[base+i].md = md;
      vt[base+i].ps = W'($urandom);
      vt[base+i].rm = W'($urandom);
      vt[base+i].nf = md ? int'($urandom_range(0, 3)) : 0;
      vt[base+i].ne = md ? int'($urandom_range(0, 4)) : 0;
      vt[base+i].ovr = 1'b0;
      vt[base+i].smid = 1'b0;
      vt[base+i].exp = ref_total(md, vt[base+i].ps, vt[base+i].rm);
    end
  endtask

  task automatic all_zero(input string name);
    chk(name, {total_sum, total_vld, row_cnt, done, err, overrun,
               fifo_if.sum_out, fifo_if.sum_out_vld, fifo_if.fifo_ext_rd}, 0);
  endtask

  initial begin
    // Mode-0 pass: totals equal the local sums 10..17.
    for (int i = 0; i < ROWS; i++) vt[i] = '{0, W'(10 + i), '0, 0, 0, 0, 0, (W+1)'(10 + i)};
    // Mode-1 pass: max values, stalls, stray psum_vld, ignored mid-pass start.
    vt[8]  = '{1, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 0, 25'h1FFFFFE};
    vt[9]  = '{1, 24'h000001, 24'h000002, 5, 0, 0, 0, 25'h0000003};
    vt[10] = '{1, 24'h123456, 24'h654321, 0, 3, 0, 0, 25'h0777777};
    vt[11] = '{1, 24'h000000, 24'h000000, 2, 2, 0, 0, 25'h0000000};
    vt[12] = '{1, 24'hABCDEF, 24'h000001, 0, 2, 1, 0, 25'h0ABCDF0};
    vt[13] = '{1, 24'h100000, 24'h0FFFFF, 1, 0, 0, 1, 25'h01FFFFF};
    vt[14] = '{1, 24'hFFFFFF, 24'h000000, 0, 1, 0, 0, 25'h0FFFFFF};
    vt[15] = '{1, 24'h000000, 24'hFFFFFF, 0, 0, 0, 0, 25'h0FFFFFF};

    idle_in();
    #3 reset = 1'b1;
    adv(); adv();
    all_zero("reset_outputs");
    reset = 1'b0;
    adv();
    all_zero("post_reset_idle");

    run_pass(0, 1'b0, 1'b0, "m0");
    run_pass(8, 1'b1, 1'b1, "m1");

    // Timeout on the third row, then restart from ERR with a random pass.
    begin
      int wr, rd;
      wr = 0; rd = 0;
      do_start(1'b1, "tmo");
      run_row(vt[8], 0, "tmo");
      run_row(vt[9], 1, "tmo");
      for (int c = 0; c < 26; c++) begin
        psum_vld = (c == 0); psum_in = 24'h0000AA; mode = 1'b1;
        #1;
        if (fifo_if.sum_out_vld) wr++;
        if (fifo_if.fifo_ext_rd) rd++;
        if (c == 16) chk("tmo_err_before_limit", err, 0);
        if (c == 17) chk("tmo_err_at_limit", err, 1);
        if (c == 25) chk("tmo_err_sticky", err, 1);
        adv();
      end
      idle_in();
      chk("tmo_writes", wr, 1);
      chk("tmo_reads", rd, 0);
      chk("tmo_row_cnt_held", row_cnt, 2);
      chk("tmo_no_total", total_vld, 0);
    end
    fill_random(16, 1'b1);
    run_pass(16, 1'b1, 1'b0, "after_err");

    // Reset while waiting for remote data on row 3.
    fill_random(24, 1'b1);
    do_start(1'b1, "rst");
    for (int i = 0; i < 3; i++) run_row(vt[24 + i], i, "rst");
    for (int c = 0; c < 4; c++) begin
      psum_vld = (c == 0); psum_in = 24'h000055;
      adv();
    end
    idle_in();
    chk("rst_row_cnt_before", row_cnt, 3);
    reset = 1'b1;
    #1;
    fifo_if.sum_rd_vld = 1'b1;
    #1;
    all_zero("rst_async_outputs");
    adv();
    all_zero("rst_held_outputs");
    reset = 1'b0;
    fifo_if.sum_rd_vld = 1'b0;
    adv();
    fill_random(24, 1'b1);
    run_pass(24, 1'b1, 1'b0, "post_rst");

    fill_random(16, 1'b0);
    run_pass(16, 1'b0, 1'b0, "rand_m0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
